sb_msg_arbiter: RTL and testbench

Parametrised successor to the MBINIT two-channel parameter-exchange wrapper. It arbitrates sideband message requests from NUM_CH sub-state engines (TX/RX parameter, calibration, repair, etc.) onto the single sideband encoder. The result is registered, handshaken and timeout-protected. It also aggregates per-channel completion and error into one phase-end and one error signal for the LTSM.

---
 rtl/sb_msg_arbiter.sv | 136 +++++++++++++
 tb/tb_sb_msg_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sb_msg_arbiter.sv
// Sideband message arbiter: grants one of NUM_CH requesters onto the encoder,
// waits for the busy falling edge, and aggregates per-channel done/error.
module sb_msg_arbiter #(
    parameter int SB_MSG_Width = 4,
    parameter int NUM_CH       = 2,
    parameter int RR_MODE      = 1,
    parameter int TIMEOUT_CYC  = 1024,
    parameter logic [NUM_CH-1:0] END_MASK = {NUM_CH{1'b1}}
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_en,
    input  logic [NUM_CH-1:0]              i_req_valid,
    input  logic [NUM_CH*SB_MSG_Width-1:0] i_req_msg,
    input  logic [NUM_CH-1:0]              i_ch_done,
    input  logic [NUM_CH-1:0]              i_ch_error,
    input  logic                           i_sb_busy,
    input  logic                           i_falling_edge_busy,
    output logic [SB_MSG_Width-1:0]        o_encoded_SB_msg,
    output logic                           o_msg_valid,
    output logic [NUM_CH-1:0]              o_ack,
    output logic [NUM_CH-1:0]              o_grant,
    output logic                           o_phase_end,
    output logic                           o_error_req,
    output logic                           o_timeout
);

    localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [PW-1:0] P_LAST = PW'(NUM_CH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT,
        ACK
    } state_t;

    state_t state;

    logic [PW-1:0]           ptr;
    logic [PW-1:0]           gnt_idx;
    logic [PW-1:0]           win_idx;
    logic [NUM_CH-1:0]       win_oh;
    logic                    win_found;
    logic [SB_MSG_Width-1:0] win_msg;
    logic [TW-1:0]           timer;
    logic [NUM_CH-1:0]       done_flags;
    logic [NUM_CH-1:0]       done_next;

    // Search starts at the pointer in round-robin mode, at 0 otherwise.
    function automatic int cand(input int base, input int i);
        return (base + i) % NUM_CH;
    endfunction

    always_comb begin
        win_idx   = '0;
        win_oh    = '0;
        win_found = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!win_found &&
                i_req_valid[cand((RR_MODE != 0) ? int'(ptr) : 0, i)]) begin
                win_found = 1'b1;
                win_idx   = PW'(cand((RR_MODE != 0) ? int'(ptr) : 0, i));
            end
        end
        if (win_found) begin
            win_oh[win_idx] = 1'b1;
        end
        win_msg = i_req_msg[int'(win_idx)*SB_MSG_Width +: SB_MSG_Width];
    end

    assign done_next = done_flags | i_ch_done;

    always_ff @(posedge i_clk) begin
        if (i_rst || !i_en) begin
            state            <= IDLE;
            ptr              <= '0;
            gnt_idx          <= '0;
            timer            <= '0;
            done_flags       <= '0;
            o_encoded_SB_msg <= '0;
            o_msg_valid      <= 1'b0;
            o_ack            <= '0;
            o_grant          <= '0;
            o_phase_end      <= 1'b0;
            o_error_req      <= 1'b0;
            o_timeout        <= 1'b0;
        end else begin
            o_msg_valid <= 1'b0;
            o_ack       <= '0;
            done_flags  <= done_next;
            o_phase_end <= (done_next & END_MASK) == END_MASK;
            if (|i_ch_error) begin
                o_error_req <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (win_found && !i_sb_busy && !o_error_req) begin
                        o_encoded_SB_msg <= win_msg;
                        o_grant          <= win_oh;
                        gnt_idx          <= win_idx;
                        state            <= SEND;
                    end
                end
                SEND: begin
                    o_msg_valid <= 1'b1;
                    timer       <= '0;
                    state       <= WAIT;
                end
                WAIT: begin
                    // A falling edge on the last timer cycle still completes.
                    if (i_falling_edge_busy) begin
                        o_ack <= o_grant;
                        state <= ACK;
                    end else if (timer == T_LAST) begin
                        o_error_req <= 1'b1;
                        o_timeout   <= 1'b1;
                        o_grant     <= '0;
                        state       <= IDLE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                ACK: begin
                    o_grant <= '0;
                    ptr     <= (gnt_idx == P_LAST) ? '0 : gnt_idx + PW'(1);
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sb_msg_arbiter.sv
// Directed bench for sb_msg_arbiter: a 2-channel round-robin instance (a_*)
// and a 4-channel fixed-priority instance (b_*), both with a 16-cycle timeout.
module tb_sb_msg_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    logic       a_rst, a_en, a_busy, a_fe;
    logic [1:0] a_req_valid, a_done, a_err;
    logic [7:0] a_req_msg;
    logic [3:0] a_msg;
    logic       a_mv, a_pe, a_er, a_to;
    logic [1:0] a_ack, a_grant;

    logic        b_rst, b_en, b_busy, b_fe;
    logic [3:0]  b_req_valid, b_done, b_err;
    logic [15:0] b_req_msg;
    logic [3:0]  b_msg;
    logic        b_mv, b_pe, b_er, b_to;
    logic [3:0]  b_ack, b_grant;

    sb_msg_arbiter #(
        .SB_MSG_Width(4), .NUM_CH(2), .RR_MODE(1), .TIMEOUT_CYC(16)
    ) u_a (
        .i_clk(clk), .i_rst(a_rst), .i_en(a_en),
        .i_req_valid(a_req_valid), .i_req_msg(a_req_msg),
        .i_ch_done(a_done), .i_ch_error(a_err),
        .i_sb_busy(a_busy), .i_falling_edge_busy(a_fe),
        .o_encoded_SB_msg(a_msg), .o_msg_valid(a_mv), .o_ack(a_ack),
        .o_grant(a_grant), .o_phase_end(a_pe), .o_error_req(a_er),
        .o_timeout(a_to)
    );

    sb_msg_arbiter #(
        .SB_MSG_Width(4), .NUM_CH(4), .RR_MODE(0), .TIMEOUT_CYC(16)
    ) u_b (
        .i_clk(clk), .i_rst(b_rst), .i_en(b_en),
        .i_req_valid(b_req_valid), .i_req_msg(b_req_msg),
        .i_ch_done(b_done), .i_ch_error(b_err),
        .i_sb_busy(b_busy), .i_falling_edge_busy(b_fe),
        .o_encoded_SB_msg(b_msg), .o_msg_valid(b_mv), .o_ack(b_ack),
        .o_grant(b_grant), .o_phase_end(b_pe), .o_error_req(b_er),
        .o_timeout(b_to)
    );

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic test_reset;
        a_rst = 1'b1; b_rst = 1'b1; a_en = 1'b1; b_en = 1'b1;
        tick; tick;
        n_chk++;
        if ({a_msg, a_mv, a_ack, a_grant, a_pe, a_er, a_to} !== 12'h0)
            $display("FAIL reset_a: got %h expected 0",
                     {a_msg, a_mv, a_ack, a_grant, a_pe, a_er, a_to});
        else n_pass++;
        n_chk++;
        if ({b_msg, b_mv, b_ack, b_grant, b_pe, b_er, b_to} !== 16'h0)
            $display("FAIL reset_b: got %h expected 0",
                     {b_msg, b_mv, b_ack, b_grant, b_pe, b_er, b_to});
        else n_pass++;
        a_rst = 1'b0; b_rst = 1'b0;
        tick;
    endtask

    task automatic test_single;
        a_req_msg = 8'h03; a_req_valid = 2'b01;
        tick;
        n_chk++;
        if (a_grant !== 2'b01) $display("FAIL single_grant: got %b expected 01", a_grant);
        else n_pass++;
        n_chk++;
        if (a_mv !== 1'b0) $display("FAIL single_mv_early: got %b expected 0", a_mv);
        else n_pass++;
        a_req_msg = 8'h0F;
        tick;
        n_chk++;
        if (a_mv !== 1'b1) $display("FAIL single_mv: got %b expected 1", a_mv);
        else n_pass++;
        n_chk++;
        if (a_msg !== 4'h3) $display("FAIL single_msg: got %h expected 3", a_msg);
        else n_pass++;
        tick;
        n_chk++;
        if (a_mv !== 1'b0) $display("FAIL single_mv_pulse: got %b expected 0", a_mv);
        else n_pass++;
        repeat (4) tick;
        a_fe = 1'b1;
        tick;
        a_fe = 1'b0;
        n_chk++;
        if (a_ack !== 2'b01) $display("FAIL single_ack: got %b expected 01", a_ack);
        else n_pass++;
        a_req_valid = 2'b00;
        tick;
        n_chk++;
        if ({a_ack, a_grant} !== 4'b0000)
            $display("FAIL single_ack_clear: got %b expected 0000", {a_ack, a_grant});
        else n_pass++;
        tick;
    endtask

    task automatic test_rr;
        int n;
        int e;
        a_en = 1'b0;
        tick;
        a_en = 1'b1; a_req_msg = 8'hA5; a_req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (a_mv !== 1'b1 && n < 10) begin tick; n++; end
            e = k % 2;
            n_chk++;
            if (a_mv !== 1'b1) $display("FAIL rr_mv_wait: got %b expected 1", a_mv);
            else n_pass++;
            n_chk++;
            if (a_grant !== ((e == 0) ? 2'b01 : 2'b10))
                $display("FAIL rr_grant%0d: got %b expected ch%0d", k, a_grant, e);
            else n_pass++;
            n_chk++;
            if (a_msg !== ((e == 0) ? 4'h5 : 4'hA))
                $display("FAIL rr_msg%0d: got %h expected ch%0d msg", k, a_msg, e);
            else n_pass++;
            if (k > 0) begin
                n_chk++;
                if (n !== 2) $display("FAIL rr_spacing%0d: got %0d expected 2", k, n);
                else n_pass++;
            end
            a_fe = 1'b1;
            tick;
            a_fe = 1'b0;
            n_chk++;
            if (a_ack !== ((e == 0) ? 2'b01 : 2'b10))
                $display("FAIL rr_ack%0d: got %b expected ch%0d", k, a_ack, e);
            else n_pass++;
            tick;
        end
        a_req_valid = 2'b00;
        tick; tick;
    endtask

    task automatic test_fixed;
        int n;
        int e;
        b_req_msg = 16'h4321; b_req_valid = 4'b1011;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (b_mv !== 1'b1 && n < 10) begin tick; n++; end
            e = (k < 3) ? 0 : 1;
            n_chk++;
            if (b_grant !== ((e == 0) ? 4'b0001 : 4'b0010))
                $display("FAIL fp_grant%0d: got %b expected ch%0d", k, b_grant, e);
            else n_pass++;
            n_chk++;
            if (b_msg !== ((e == 0) ? 4'h1 : 4'h2))
                $display("FAIL fp_msg%0d: got %h expected ch%0d msg", k, b_msg, e);
            else n_pass++;
            b_fe = 1'b1;
            tick;
            b_fe = 1'b0;
            n_chk++;
            if (b_ack !== ((e == 0) ? 4'b0001 : 4'b0010))
                $display("FAIL fp_ack%0d: got %b expected ch%0d", k, b_ack, e);
            else n_pass++;
            if (k == 2) b_req_valid = 4'b1010;
            if (k == 3) b_req_valid = 4'b0000;
            tick;
        end
        tick;
    endtask

    task automatic test_phase_end;
        int ord[4] = '{2, 0, 3, 1};
        b_en = 1'b0;
        tick;
        b_en = 1'b1;
        tick;
        for (int i = 0; i < 4; i++) begin
            b_done = 4'(1 << ord[i]);
            if (i == 3) b_err = 4'b0010;
            tick;
            b_done = 4'b0000; b_err = 4'b0000;
            n_chk++;
            if (b_pe !== (i == 3))
                $display("FAIL pe_step%0d: got %b expected %b", i, b_pe, (i == 3));
            else n_pass++;
            n_chk++;
            if (b_er !== (i == 3))
                $display("FAIL pe_err%0d: got %b expected %b", i, b_er, (i == 3));
            else n_pass++;
            tick;
        end
        repeat (3) tick;
        n_chk++;
        if (b_pe !== 1'b1) $display("FAIL pe_sticky: got %b expected 1", b_pe);
        else n_pass++;
        b_en = 1'b0;
        tick;
        n_chk++;
        if ({b_msg, b_mv, b_ack, b_grant, b_pe, b_er, b_to} !== 16'h0)
            $display("FAIL en_low_b: got %h expected 0",
                     {b_msg, b_mv, b_ack, b_grant, b_pe, b_er, b_to});
        else n_pass++;
        b_en = 1'b1;
        tick;
        n_chk++;
        if ({b_pe, b_er} !== 2'b00)
            $display("FAIL en_relaunch_b: got %b expected 00", {b_pe, b_er});
        else n_pass++;
    endtask

    task automatic test_timeout;
        int n;
        int acks;
        int bad;
        a_en = 1'b0;
        tick;
        a_en = 1'b1; a_req_msg = 8'h07; a_req_valid = 2'b01;
        n = 0;
        while (a_mv !== 1'b1 && n < 10) begin tick; n++; end
        n_chk++;
        if (a_msg !== 4'h7) $display("FAIL to_msg: got %h expected 7", a_msg);
        else n_pass++;
        acks = 0;
        for (int i = 1; i <= 16; i++) begin
            tick;
            if (a_ack !== 2'b00) acks++;
            if (i == 15) begin
                n_chk++;
                if (a_er !== 1'b0) $display("FAIL to_early: got %b expected 0", a_er);
                else n_pass++;
            end
        end
        n_chk++;
        if ({a_er, a_to} !== 2'b11) $display("FAIL to_flags: got %b expected 11", {a_er, a_to});
        else n_pass++;
        n_chk++;
        if (a_grant !== 2'b00) $display("FAIL to_grant: got %b expected 00", a_grant);
        else n_pass++;
        n_chk++;
        if (acks !== 0) $display("FAIL to_noack: got %0d expected 0", acks);
        else n_pass++;
        bad = 0;
        repeat (8) begin
            tick;
            if (a_mv !== 1'b0 || a_grant !== 2'b00) bad++;
        end
        n_chk++;
        if (bad !== 0) $display("FAIL to_nogrant: got %0d expected 0", bad);
        else n_pass++;
        a_req_valid = 2'b00;
    endtask

    task automatic test_error_inflight;
        int n;
        int bad;
        a_en = 1'b0;
        tick;
        a_en = 1'b1; a_req_msg = 8'h9C; a_req_valid = 2'b10;
        n = 0;
        while (a_mv !== 1'b1 && n < 10) begin tick; n++; end
        n_chk++;
        if (a_grant !== 2'b10) $display("FAIL err_grant: got %b expected 10", a_grant);
        else n_pass++;
        a_req_valid = 2'b11; a_err = 2'b10;
        tick;
        a_err = 2'b00;
        n_chk++;
        if ({a_er, a_to} !== 2'b10) $display("FAIL err_flag: got %b expected 10", {a_er, a_to});
        else n_pass++;
        tick;
        a_fe = 1'b1;
        tick;
        a_fe = 1'b0;
        n_chk++;
        if (a_ack !== 2'b10) $display("FAIL err_ack: got %b expected 10", a_ack);
        else n_pass++;
        a_req_valid = 2'b01;
        bad = 0;
        repeat (8) begin
            tick;
            if (a_mv !== 1'b0 || a_grant !== 2'b00) bad++;
        end
        n_chk++;
        if (bad !== 0) $display("FAIL err_nogrant: got %0d expected 0", bad);
        else n_pass++;
        a_req_valid = 2'b00;
    endtask

    task automatic test_reset_midflight;
        int n;
        a_en = 1'b0;
        tick;
        a_en = 1'b1; a_req_msg = 8'hB6; a_req_valid = 2'b01;
        n = 0;
        while (a_mv !== 1'b1 && n < 10) begin tick; n++; end
        a_fe = 1'b1;
        tick;
        a_fe = 1'b0;
        n_chk++;
        if (a_ack !== 2'b01) $display("FAIL rst_first_ack: got %b expected 01", a_ack);
        else n_pass++;
        n = 0;
        tick;
        while (a_mv !== 1'b1 && n < 10) begin tick; n++; end
        n_chk++;
        if (a_grant !== 2'b01) $display("FAIL rst_regrant: got %b expected 01", a_grant);
        else n_pass++;
        a_rst = 1'b1; a_req_valid = 2'b11;
        tick;
        n_chk++;
        if ({a_msg, a_mv, a_ack, a_grant, a_pe, a_er, a_to} !== 12'h0)
            $display("FAIL rst_mid: got %h expected 0",
                     {a_msg, a_mv, a_ack, a_grant, a_pe, a_er, a_to});
        else n_pass++;
        a_rst = 1'b0;
        n = 0;
        while (a_mv !== 1'b1 && n < 10) begin tick; n++; end
        n_chk++;
        if (a_grant !== 2'b01) $display("FAIL rst_ptr: got %b expected 01", a_grant);
        else n_pass++;
        n_chk++;
        if (a_msg !== 4'h6) $display("FAIL rst_msg: got %h expected 6", a_msg);
        else n_pass++;
        a_fe = 1'b1;
        tick;
        a_fe = 1'b0;
        n_chk++;
        if (a_ack !== 2'b01) $display("FAIL rst_ack: got %b expected 01", a_ack);
        else n_pass++;
        a_req_valid = 2'b00;
        tick;
    endtask

    initial begin
        a_rst = 1'b1; a_en = 1'b0; a_busy = 1'b0; a_fe = 1'b0;
        a_req_valid = '0; a_req_msg = '0; a_done = '0; a_err = '0;
        b_rst = 1'b1; b_en = 1'b0; b_busy = 1'b0; b_fe = 1'b0;
        b_req_valid = '0; b_req_msg = '0; b_done = '0; b_err = '0;
        test_reset;
        test_single;
        test_rr;
        test_fixed;
        test_phase_end;
        test_timeout;
        test_error_inflight;
        test_reset_midflight;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
